baud_gen_frac: RTL

BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

---
 rtl/baud_gen_frac.sv | 136 +++++++++++++
 1 files changed

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: oversample tick (rx_tick), bit-rate tick
// (tx_tick) and rx oversample index, derived from a programmable divisor with
// a first-order fractional accumulator.
module baud_gen_frac #(
  parameter int unsigned CLK_FREQ   = 10_000_000,
  parameter int unsigned BAUD_RATE  = 9_600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FRAC_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [DIV_W-1:0]              div_int,
  input  logic [FRAC_W-1:0]             div_frac,
  input  logic                          div_load,
  input  logic                          rx_resync,
  output logic                          rx_tick,
  output logic                          tx_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] rx_idx
);

  localparam int unsigned IDX_W = $clog2(OVERSAMPLE);

  // Reset divisor derived from the clock and baud parameters in 64-bit math.
  localparam logic [63:0] TICK_RATE  = 64'(BAUD_RATE) * 64'(OVERSAMPLE);
  localparam logic [63:0] DEF_INT_L  = 64'(CLK_FREQ) / TICK_RATE;
  localparam logic [63:0] DEF_FRAC_L =
    ((64'(CLK_FREQ) << FRAC_W) / TICK_RATE) % (64'(1) << FRAC_W);

  localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEF_INT_L);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_FRAC_L);
  localparam logic [DIV_W-1:0]  MIN_INT  = DIV_W'(2);
  localparam logic [DIV_W-1:0]  DEF_CNT  =
    ((DEF_INT < MIN_INT) ? MIN_INT : DEF_INT) - DIV_W'(1);
  localparam logic [IDX_W-1:0]  OS_LAST  = IDX_W'(OVERSAMPLE - 1);

  // Shadow divisor registers
  logic [DIV_W-1:0]  shadow_int;
  logic [FRAC_W-1:0] shadow_frac;

  // Counting state
  logic [DIV_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic [IDX_W-1:0]  tx_os;

  // Divisor path
  logic [DIV_W-1:0]  act_int_c;
  logic [FRAC_W-1:0] act_frac_c;
  logic [DIV_W-1:0]  eff_int_c;
  logic [FRAC_W:0]   frac_sum_c;
  logic [DIV_W-1:0]  restart_cnt_c;
  logic [DIV_W-1:0]  reload_cnt_c;
  logic              tx_wrap_c;
  logic              rx_wrap_c;

  // Next-state values
  logic [DIV_W-1:0]  cnt_nxt;
  logic [FRAC_W-1:0] acc_nxt;
  logic [IDX_W-1:0]  tx_os_nxt;
  logic [IDX_W-1:0]  rx_idx_nxt;
  logic              rx_tick_nxt;
  logic              tx_tick_nxt;

  // Active divisor: a same-cycle load is visible to resync/reload/immediate load
  always_comb begin
    act_int_c     = div_load ? div_int  : shadow_int;
    act_frac_c    = div_load ? div_frac : shadow_frac;
    eff_int_c     = (act_int_c < MIN_INT) ? MIN_INT : act_int_c;
    frac_sum_c    = {1'b0, acc} + {1'b0, act_frac_c};
    restart_cnt_c = eff_int_c - DIV_W'(1);
    reload_cnt_c  = restart_cnt_c + DIV_W'(frac_sum_c[FRAC_W]);
    tx_wrap_c     = (tx_os == OS_LAST);
    rx_wrap_c     = (rx_idx == OS_LAST);
  end

  // Next-state: resync beats reload; disabled counter holds except on a load
  always_comb begin
    cnt_nxt     = cnt;
    acc_nxt     = acc;
    tx_os_nxt   = tx_os;
    rx_idx_nxt  = rx_idx;
    rx_tick_nxt = 1'b0;
    tx_tick_nxt = 1'b0;
    if (rx_resync) begin
      cnt_nxt    = restart_cnt_c;
      acc_nxt    = '0;
      rx_idx_nxt = '0;
    end else if (en) begin
      if (cnt == '0) begin
        cnt_nxt     = reload_cnt_c;
        acc_nxt     = frac_sum_c[FRAC_W-1:0];
        rx_tick_nxt = 1'b1;
        tx_tick_nxt = tx_wrap_c;
        tx_os_nxt   = tx_wrap_c ? '0 : tx_os + IDX_W'(1);
        rx_idx_nxt  = rx_wrap_c ? '0 : rx_idx + IDX_W'(1);
      end else begin
        cnt_nxt = cnt - DIV_W'(1);
      end
    end else if (div_load) begin
      cnt_nxt = restart_cnt_c;
      acc_nxt = '0;
    end
  end

  // Shadow divisor capture
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_int  <= DEF_INT;
      shadow_frac <= DEF_FRAC;
    end else if (div_load) begin
      shadow_int  <= div_int;
      shadow_frac <= div_frac;
    end
  end

  // Counter, accumulator, phase counters and tick outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= DEF_CNT;
      acc     <= '0;
      tx_os   <= '0;
      rx_idx  <= '0;
      rx_tick <= 1'b0;
      tx_tick <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      acc     <= acc_nxt;
      tx_os   <= tx_os_nxt;
      rx_idx  <= rx_idx_nxt;
      rx_tick <= rx_tick_nxt;
      tx_tick <= tx_tick_nxt;
    end
  end

endmodule
